stoch_activation: RTL

STOCH_ACTIVATION -- requirements
Module: stoch_activation

---
 rtl/stoch_pkg.sv | 18 +
 rtl/stoch_fsm_cell.sv | 67 ++++++
 rtl/stoch_activation.sv | 62 ++++++
 3 files changed

// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic activation block: activation mode
// encoding and default parameter values used by the top and the channel cell.
package stoch_pkg;

   // Activation mode as presented on the mode port. RSVD decodes as TANH.
   typedef enum logic [1:0] {
      TANH   = 2'b00,
      EXP    = 2'b01,
      RSVD   = 2'b10,
      BYPASS = 2'b11
   } mode_t;

   localparam int DEF_CHANNELS = 4;
   localparam int DEF_STATES   = 16;
   localparam int DEF_G_EXP    = 2;
   localparam int DEF_WARMUP   = 32;

endpackage

// File: rtl/stoch_fsm_cell.sv
// One stochastic-computing channel: a saturating up/down counter driven by the
// input bitstream, followed by a registered output bit whose meaning depends
// on the activation mode (threshold at mid for TANH, near-top threshold for
// EXP, or a plain one-cycle delay of x for BYPASS).
module stoch_fsm_cell
   import stoch_pkg::*;
#(
   parameter int STATES = DEF_STATES,
   parameter int G_EXP  = DEF_G_EXP
)(
   input  logic  clk,
   input  logic  n_rst,
   input  logic  en,
   input  logic  clr,
   input  mode_t mode,
   input  logic  x,
   output logic  y
);

   localparam int SW = $clog2(STATES);
   localparam logic [SW-1:0] MID    = SW'(STATES / 2);
   localparam logic [SW-1:0] TOP    = SW'(STATES - 1);
   localparam logic [SW-1:0] EXP_TH = SW'(STATES - G_EXP);
   localparam logic [SW-1:0] ONE    = SW'(1);

   logic [SW-1:0] state_reg;
   logic [SW-1:0] state_next;
   logic          y_reg;
   logic          y_next;

   // Saturating step toward the rail selected by the input bit.
   always_comb begin
      state_next = state_reg;
      if (x) begin
         if (state_reg != TOP) state_next = state_reg + ONE;
      end else begin
         if (state_reg != '0) state_next = state_reg - ONE;
      end
   end

   // Output decode uses the post-update state so y lags x by exactly one edge.
   always_comb begin
      y_next = 1'b0;
      case (mode)
         EXP:     y_next = (state_next < EXP_TH);
         BYPASS:  y_next = x;
         default: y_next = (state_next >= MID);
      endcase
   end

   // State and output registers: reset/clear return to mid with y low.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_reg <= MID;
         y_reg     <= 1'b0;
      end else if (clr) begin
         state_reg <= MID;
         y_reg     <= 1'b0;
      end else if (en) begin
         state_reg <= state_next;
         y_reg     <= y_next;
      end
   end

   assign y = y_reg;

endmodule

// File: rtl/stoch_activation.sv
// Multi-channel stochastic activation function. Each channel is an independent
// saturating FSM cell; a single shared warm-up counter flags the outputs valid
// once enough enabled cycles have elapsed since reset or clear.
module stoch_activation
   import stoch_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int STATES   = DEF_STATES,
   parameter int G_EXP    = DEF_G_EXP,
   parameter int WARMUP   = DEF_WARMUP
)(
   input  logic                clk,
   input  logic                n_rst,
   input  logic                en,
   input  logic                clr,
   input  logic [1:0]          mode,
   input  logic [CHANNELS-1:0] x,
   output logic [CHANNELS-1:0] y,
   output logic                valid
);

   localparam int WW = $clog2(WARMUP + 1);
   localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);
   localparam logic [WW-1:0] WARM_ONE = WW'(1);

   mode_t         mode_sel;
   logic [WW-1:0] warm_reg;

   assign mode_sel = mode_t'(mode);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         stoch_fsm_cell #(
            .STATES (STATES),
            .G_EXP  (G_EXP)
         ) u_cell (
            .clk   (clk),
            .n_rst (n_rst),
            .en    (en),
            .clr   (clr),
            .mode  (mode_sel),
            .x     (x[gi]),
            .y     (y[gi])
         );
      end
   endgenerate

   // Warm-up counter: counts enabled cycles, sticks at WARMUP.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         warm_reg <= '0;
      end else if (clr) begin
         warm_reg <= '0;
      end else if (en && (warm_reg != WARM_MAX)) begin
         warm_reg <= warm_reg + WARM_ONE;
      end
   end

   assign valid = (warm_reg == WARM_MAX);

endmodule
